// File: rtl/bram_fifo_arbiter_pkg.sv
// Shared firmware constants for the BRAM-backed FIFO and the BRAM it drives,
// plus the writer-select type and the round-robin pick used by the arbiter.
//   FIFO_AW    : BRAM address width
//   FIFO_DW    : data width
//   FIFO_DEPTH : ring capacity in entries (2**FIFO_AW)
package bram_fifo_arbiter_pkg;

    localparam int FIFO_AW    = 11;
    localparam int FIFO_DW    = 8;
    localparam int FIFO_DEPTH = 2 ** FIFO_AW;

    typedef enum logic {
        WR0 = 1'b0,
        WR1 = 1'b1
    } writer_e;

    // A lone requester wins; on a tie the writer that did not win last time wins.
    function automatic writer_e rr_pick(input logic v0, input logic v1, input writer_e last);
        if (v0 && v1) begin
            return (last == WR1) ? WR0 : WR1;
        end
        return v0 ? WR0 : WR1;
    endfunction

endpackage

// File: rtl/bram_fifo_skid.sv
// Two-entry output buffer that sits behind the BRAM read port.
//   clk, reset     : clock, asynchronous active-low reset
//   clear          : synchronous discard of all entries (wins over load)
//   load/load_data : capture one word from the BRAM read data
//   pop            : head consumed by the reader (ignored when empty)
//   valid/data     : buffer non-empty / head entry
//   count          : entries held, 0..2
module bram_fifo_skid
    import bram_fifo_arbiter_pkg::*;
#(
    parameter int DW = FIFO_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          pop,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic [1:0]    count
);

    logic [DW-1:0] head;
    logic [DW-1:0] tail;
    logic          do_pop;

    assign do_pop = pop && (count != 2'd0);
    assign valid  = (count != 2'd0);
    assign data   = head;

    // The parent only issues a read when there will be room for it, so a load
    // into a full buffer without a pop never happens.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    // NOTE: the two data entries are plain flops, not a RAM, so they are reset
    // with count; rd_data then reads 0 during reset instead of X.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else if (clear) begin
            count <= 2'd0;
        end else begin
            case ({load, do_pop})
                2'b10: begin
                    if (count == 2'd0) head <= load_data;
                    else               tail <= load_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= load_data;
                    end else begin
                        head <= tail;
                        tail <= load_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bram_fifo_arbiter.sv
// Two-writer, one-reader FIFO whose storage is an external dual-port BRAM.
// Writers are round-robin arbitrated (one write per cycle); reads are
// prefetched into a 2-entry skid buffer so the reader sees one word per cycle.
//   clk, reset                     : clock, asynchronous active-low reset
//   flush                          : synchronous clear of pointers, level, buffer
//   wr0_valid/wr0_data/wr0_ready   : writer 0 stream
//   wr1_valid/wr1_data/wr1_ready   : writer 1 stream
//   rd_valid/rd_data/rd_ready      : reader stream
//   mem_we/mem_a/mem_di            : BRAM write port
//   mem_dpra/mem_dpo               : BRAM read address / registered read data
//   level                          : occupancy, 0..DEPTH
module bram_fifo_arbiter
    import bram_fifo_arbiter_pkg::*;
#(
    parameter int AW    = FIFO_AW,
    parameter int DW    = FIFO_DW,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          wr0_valid,
    input  logic [DW-1:0] wr0_data,
    output logic          wr0_ready,
    input  logic          wr1_valid,
    input  logic [DW-1:0] wr1_data,
    output logic          wr1_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          rd_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_di,
    output logic [AW-1:0] mem_dpra,
    input  logic [DW-1:0] mem_dpo,
    output logic [AW:0]   level
);

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [AW:0]   wr_ptr;
    logic [AW:0]   fetch_ptr;
    logic [AW-1:0] dpra_q;
    logic          inflight;
    writer_e       last_grant;
    writer_e       pick;
    logic          grant;
    logic          fetch;
    logic          pop;
    logic [1:0]    skid_count;

    // Reset is folded into the grant so ready and mem_we drop the moment reset
    // falls instead of waiting for the next edge.
    // The fetch address goes straight to mem_dpra: the BRAM samples it on the
    // coming edge and the word lands in the skid one edge later, which gives
    // the two-edge write-to-read latency. When idle the last address is held.
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        pick      = rr_pick(wr0_valid, wr1_valid, last_grant);
        grant     = reset && !flush && (level != FULL_LEVEL) && (wr0_valid || wr1_valid);
        wr0_ready = grant && (pick == WR0);
        wr1_ready = grant && (pick == WR1);
        mem_we    = grant;
        mem_a     = wr_ptr[AW-1:0];
        mem_di    = (pick == WR0) ? wr0_data : wr1_data;
        pop       = rd_valid && rd_ready;
        // Room check: words held + word in flight - word leaving now < 2.
        fetch     = !flush && (fetch_ptr != wr_ptr) &&
                    (({1'b0, skid_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
        mem_dpra  = fetch ? fetch_ptr[AW-1:0] : dpra_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            fetch_ptr  <= '0;
            level      <= '0;
            inflight   <= 1'b0;
            dpra_q     <= '0;
            last_grant <= WR1;
        end else if (flush) begin
            // The round-robin pointer and held read address survive a flush.
            wr_ptr    <= '0;
            fetch_ptr <= '0;
            level     <= '0;
            inflight  <= 1'b0;
        end else begin
            if (grant) begin
                wr_ptr     <= wr_ptr + 1'b1;
                last_grant <= pick;
            end
            if (fetch) begin
                fetch_ptr <= fetch_ptr + 1'b1;
                dpra_q    <= fetch_ptr[AW-1:0];
            end
            inflight <= fetch;
            level    <= level + {{AW{1'b0}}, grant} - {{AW{1'b0}}, pop};
        end
    end

    bram_fifo_skid #(
        .DW(DW)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .load      (inflight),
        .load_data (mem_dpo),
        .pop       (pop),
        .valid     (rd_valid),
        .data      (rd_data),
        .count     (skid_count)
    );

endmodule

// File: doc/bram_fifo_arbiter.md
BRAM_FIFO_ARBITER -- requirements
Module: bram_fifo_arbiter

Interface
REQ-001 SHALL have parameter AW, default 11, meaning the BRAM address width.
REQ-002 SHALL have parameter DW, default 8, meaning the data width.
REQ-003 SHALL have parameter DEPTH, default 2048 (2**AW), meaning the ring capacity in entries.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous clear of pointers, occupancy and output buffer.
REQ-007 wr0_valid/wr0_data/wr0_ready  in/in/out  1/DW/1  writer 0 valid/ready stream.
REQ-008 wr1_valid/wr1_data/wr1_ready  in/in/out  1/DW/1  writer 1 valid/ready stream.
REQ-009 rd_valid/rd_data/rd_ready  out/out/in  1/DW/1  reader valid/ready stream.
REQ-010 mem_we/mem_a/mem_di  out  1/AW/DW  write port to the dual-port BRAM.
REQ-011 mem_dpra/mem_dpo  out/in  AW/DW  BRAM read address and registered read data (valid one edge after mem_dpra is sampled).
REQ-012 level  output  AW+1  occupancy, 0..DEPTH.

Function
REQ-013 Occupancy = writes accepted minus reader pops; full when level==DEPTH; write grants SHALL be issued only when not full.
REQ-014 At most one write per cycle; wrN_ready SHALL be combinational from the grant and SHALL be asserted only for the granted writer.
REQ-015 Arbitration: a sole valid writer is granted; when both are valid, the writer not granted last is granted (round-robin); last-grant pointer resets to writer 1 so writer 0 wins the first tie.
REQ-016 Granted write: mem_we=1, mem_a=wr_ptr[AW-1:0], mem_di=granted data; wr_ptr (AW+1 bits) increments, wrapping 4095->0 with address 2047->0.
REQ-017 Fetch: when fetch_ptr!=wr_ptr and (skid entries + in-flight reads - pop this cycle) < 2, drive mem_dpra=fetch_ptr[AW-1:0], mark in-flight, increment fetch_ptr.
REQ-018 In-flight data SHALL be captured from mem_dpo into a 2-entry output buffer on the following edge; rd_valid = buffer non-empty; rd_data = head entry.
REQ-019 Pop occurs on rd_valid&&rd_ready; sustained throughput SHALL be one write and one pop per cycle.
REQ-020 Latency: a write accepted at edge N into an empty FIFO SHALL yield rd_valid=1 after edge N+2.
REQ-021 Simultaneous write and pop: level unchanged; write while full: no grant, level stays DEPTH.
REQ-022 Read-after-write to the same address in consecutive cycles SHALL return the new data (BRAM write at edge N is visible to a read sampled at edge N+1).
REQ-023 flush SHALL zero wr_ptr, fetch_ptr, level and output buffer, discard in-flight data, force wrN_ready=0 that cycle, and keep the round-robin pointer unchanged.
REQ-024 mem_we SHALL be 0 whenever no grant is issued; mem_dpra SHALL hold its last value when not fetching.

Reset
REQ-025 While reset is low: wr_ptr, fetch_ptr, level, in-flight flag and buffer = 0; rd_valid=0; mem_we=0; wr0_ready=wr1_ready=0; mem_a=mem_dpra=0; last grant = writer 1.
REQ-026 Reset asserted mid-transfer SHALL abort immediately; BRAM contents are not cleared by this block.

Structure
REQ-027 AW, DW and DEPTH SHALL live in the shared firmware constants package/include, used by both the BRAM and this block.
REQ-028 The 2-entry output buffer SHALL be a sub-module bram_fifo_skid (clk, reset, load, load_data, pop, valid, data, count).

Verification
REQ-029 Writer 0 writes 0x41,0x42,0x43, reader ready=1 -> rd_data 0x41,0x42,0x43 in order, first rd_valid two edges after first write.
REQ-030 Both writers valid continuously (w0 0xA0.., w1 0xB0..) -> grants alternate 0,1,0,1 starting with 0; readback A0,B0,A1,B1.
REQ-031 Reader stalled, 2048 writes -> level=2048, wr0_ready=0 on write 2049; one pop -> exactly one further write accepted.
REQ-032 Fill/drain 3000 bytes with incrementing data, random rd_ready -> no loss/duplication across address wrap 2047->0.
REQ-033 flush with level=10 and one read in flight -> next cycle level=0, rd_valid=0; subsequent write 0x55 reads back 0x55.
REQ-034 reset low mid-stream -> all outputs at REQ-025 values asynchronously; after release, FIFO empty and operational.
